// File: rtl/unidade_controle_jogo_pkg.sv
// State codes and output decode shared by the memory-game control unit
// and anything that decodes db_estado (datapath top level, bench).
package unidade_controle_jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        ESPERA_JOGADA = 4'h2,
        REGISTRA      = 4'h4,
        COMPARACAO    = 4'h5,
        PROXIMO       = 4'h6,
        FIM_ACERTOU   = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERROU     = 4'hE
    } estado_t;

    typedef struct packed {
        logic zeraC;
        logic contaC;
        logic zeraR;
        logic registraR;
        logic contaT;
        logic pronto;
        logic acertou;
        logic errou;
        logic db_timeout;
    } saidas_t;

    // Moore output decode; unused codes fall through to all-zero outputs.
    function automatic saidas_t decodifica_saidas(input estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            INICIAL, PREPARACAO: begin
                s.zeraC = 1'b1;
                s.zeraR = 1'b1;
            end
            ESPERA_JOGADA: s.contaT    = 1'b1;
            REGISTRA:      s.registraR = 1'b1;
            PROXIMO:       s.contaC    = 1'b1;
            FIM_ACERTOU: begin
                s.pronto  = 1'b1;
                s.acertou = 1'b1;
            end
            FIM_TIMEOUT: begin
                s.pronto     = 1'b1;
                s.errou      = 1'b1;
                s.db_timeout = 1'b1;
            end
            FIM_ERROU: begin
                s.pronto = 1'b1;
                s.errou  = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory-game datapath: sequences one round of
// 16 plays and reports hit, error or timeout.
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
#(
    parameter int HABILITA_TIMEOUT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    input  logic       timeout,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       contaT,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    estado_t estado_q;
    estado_t estado_d;
    saidas_t saidas;
    logic    timeout_ativo;

    assign timeout_ativo = timeout && (HABILITA_TIMEOUT != 0);

    // State register with synchronous reset to inicial.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic; any unused code recovers to inicial.
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:       estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:    estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // Timeout wins over a play landing in the same cycle.
                if (timeout_ativo)     estado_d = FIM_TIMEOUT;
                else if (jogada_feita) estado_d = REGISTRA;
                else                   estado_d = ESPERA_JOGADA;
            end
            // One cycle for the sync ROM and play register to settle.
            REGISTRA:      estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)     estado_d = FIM_ERROU;
                else if (fimC)  estado_d = FIM_ACERTOU;
                else            estado_d = PROXIMO;
            end
            // Passing through proximo drops contaT, restarting the per-play timeout.
            PROXIMO:       estado_d = ESPERA_JOGADA;
            FIM_ACERTOU:   estado_d = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_TIMEOUT:   estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
            FIM_ERROU:     estado_d = iniciar ? PREPARACAO : FIM_ERROU;
            default:       estado_d = INICIAL;
        endcase
    end

    // Output decode from the state register only.
    always_comb begin
        saidas = decodifica_saidas(estado_q);
    end

    assign zeraC      = saidas.zeraC;
    assign contaC     = saidas.contaC;
    assign zeraR      = saidas.zeraR;
    assign registraR  = saidas.registraR;
    assign contaT     = saidas.contaT;
    assign pronto     = saidas.pronto;
    assign acertou    = saidas.acertou;
    assign errou      = saidas.errou;
    assign db_timeout = saidas.db_timeout;
    assign db_estado  = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench for unidade_controle_jogo: vector table plus
// hand-written round, error, timeout, reset and illegal-state sequences.
module tb_unidade_controle_jogo;
    import unidade_controle_jogo_pkg::*;

    // Expected outputs {zeraC,contaC,zeraR,registraR,contaT,pronto,acertou,errou,db_timeout}
    localparam logic [8:0] O_INI = 9'b101000000;
    localparam logic [8:0] O_ESP = 9'b000010000;
    localparam logic [8:0] O_REG = 9'b000100000;
    localparam logic [8:0] O_CMP = 9'b000000000;
    localparam logic [8:0] O_PRX = 9'b010000000;
    localparam logic [8:0] O_FA  = 9'b000001100;
    localparam logic [8:0] O_FT  = 9'b000001011;
    localparam logic [8:0] O_FE  = 9'b000001010;

    logic clock = 1'b0;
    logic reset, iniciar, jogada_feita, igual, fimC, timeout;
    logic zeraC, contaC, zeraR, registraR, contaT, pronto, acertou, errou, db_timeout;
    logic [3:0] db_estado;
    logic zeraC_n, contaC_n, zeraR_n, registraR_n, contaT_n, pronto_n, acertou_n, errou_n, db_timeout_n;
    logic [3:0] db_estado_n;

    int checks = 0;
    int errors = 0;
    int n_contaC;

    always #5 clock = ~clock;

    unidade_controle_jogo #(.HABILITA_TIMEOUT(1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fimC(fimC), .timeout(timeout),
        .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
        .contaT(contaT), .pronto(pronto), .acertou(acertou), .errou(errou),
        .db_timeout(db_timeout), .db_estado(db_estado)
    );

    unidade_controle_jogo #(.HABILITA_TIMEOUT(0)) dut_nt (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fimC(fimC), .timeout(timeout),
        .zeraC(zeraC_n), .contaC(contaC_n), .zeraR(zeraR_n), .registraR(registraR_n),
        .contaT(contaT_n), .pronto(pronto_n), .acertou(acertou_n), .errou(errou_n),
        .db_timeout(db_timeout_n), .db_estado(db_estado_n)
    );

    function automatic logic [8:0] saidas_dut();
        return {zeraC, contaC, zeraR, registraR, contaT, pronto, acertou, errou, db_timeout};
    endfunction

    task automatic chk(input string nome, input logic [8:0] atual, input logic [8:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic chk_estado(input string nome, input logic [3:0] e, input logic [8:0] o);
        chk({nome, " estado"}, {5'd0, db_estado}, {5'd0, e});
        chk({nome, " saidas"}, saidas_dut(), o);
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (contaC) n_contaC++;
    endtask

    task automatic limpa_entradas();
        reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0;
        igual = 1'b1; fimC = 1'b0; timeout = 1'b0;
    endtask

    task automatic inicia_rodada();
        limpa_entradas();
        reset = 1'b1; step(); reset = 1'b0;
        iniciar = 1'b1; step(); iniciar = 1'b0;
        step();
    endtask

    // One play from espera_jogada; leaves the FSM right after comparacao.
    task automatic jogada(input logic ig, input logic ultima);
        jogada_feita = 1'b1; step(); jogada_feita = 1'b0;
        step();
        igual = ig; fimC = ultima; step();
        igual = 1'b1; fimC = 1'b0;
    endtask

    typedef struct {
        logic       rst, ini, jf, ig, fc, to;
        logic [3:0] est;
        logic [8:0] out;
    } vetor_t;

    vetor_t tab[27];

    initial begin
        // rst ini jf ig fc to -> state, outputs
        tab[0]  = '{1,0,0,1,0,0, 4'h0, O_INI};
        tab[1]  = '{0,1,0,1,0,0, 4'h1, O_INI};
        tab[2]  = '{0,0,0,1,0,0, 4'h2, O_ESP};
        tab[3]  = '{0,0,0,1,0,0, 4'h2, O_ESP};
        tab[4]  = '{0,0,1,1,0,0, 4'h4, O_REG};
        tab[5]  = '{0,0,0,0,0,0, 4'h5, O_CMP};
        tab[6]  = '{0,0,0,1,0,0, 4'h6, O_PRX};
        tab[7]  = '{0,0,0,1,0,0, 4'h2, O_ESP};
        tab[8]  = '{0,0,1,1,0,0, 4'h4, O_REG};
        tab[9]  = '{0,0,0,1,0,0, 4'h5, O_CMP};
        tab[10] = '{0,0,0,0,0,0, 4'hE, O_FE};
        tab[11] = '{0,0,0,1,0,0, 4'hE, O_FE};
        tab[12] = '{0,0,1,1,0,0, 4'hE, O_FE};
        tab[13] = '{0,1,0,1,0,0, 4'h1, O_INI};
        tab[14] = '{0,0,0,1,0,0, 4'h2, O_ESP};
        tab[15] = '{0,0,1,1,0,1, 4'hD, O_FT};
        tab[16] = '{0,0,0,1,0,0, 4'hD, O_FT};
        tab[17] = '{0,1,0,1,0,0, 4'h1, O_INI};
        tab[18] = '{0,1,0,1,0,0, 4'h2, O_ESP};
        tab[19] = '{0,1,0,1,0,0, 4'h2, O_ESP};
        tab[20] = '{0,0,1,1,0,0, 4'h4, O_REG};
        tab[21] = '{0,0,0,1,1,0, 4'h5, O_CMP};
        tab[22] = '{0,0,0,1,1,0, 4'hA, O_FA};
        tab[23] = '{0,0,0,1,0,0, 4'hA, O_FA};
        tab[24] = '{0,0,1,1,0,0, 4'hA, O_FA};
        tab[25] = '{1,0,0,1,0,0, 4'h0, O_INI};
        tab[26] = '{0,0,1,1,0,0, 4'h0, O_INI};

        limpa_entradas();
        n_contaC = 0;
        #2;

        for (int i = 0; i < 27; i++) begin
            reset = tab[i].rst; iniciar = tab[i].ini; jogada_feita = tab[i].jf;
            igual = tab[i].ig; fimC = tab[i].fc; timeout = tab[i].to;
            step();
            chk_estado($sformatf("vec%0d", i), tab[i].est, tab[i].out);
        end

        // Full round of 16 correct plays, then restart from fim_acertou.
        inicia_rodada();
        chk_estado("round start", 4'h2, O_ESP);
        n_contaC = 0;
        for (int p = 0; p < 16; p++) begin
            jogada(1'b1, p == 15);
            if (p != 15) step();
        end
        chk("round contaC pulses", 9'(n_contaC), 9'd15);
        chk_estado("round end", 4'hA, O_FA);
        iniciar = 1'b1; step(); iniciar = 1'b0;
        chk_estado("restart prep", 4'h1, O_INI);
        step();
        chk_estado("restart espera", 4'h2, O_ESP);

        // Wrong play on the 3rd comparison.
        inicia_rodada();
        n_contaC = 0;
        jogada(1'b1, 1'b0); step();
        jogada(1'b1, 1'b0); step();
        jogada(1'b0, 1'b0);
        chk("error contaC pulses", 9'(n_contaC), 9'd2);
        chk_estado("error end", 4'hE, O_FE);

        // Timeout held in espera_jogada; disabled instance ignores it.
        inicia_rodada();
        timeout = 1'b1; step();
        chk_estado("timeout", 4'hD, O_FT);
        chk("nt stays espera", {5'd0, db_estado_n}, 9'h2);
        step();
        chk("nt still espera", {5'd0, db_estado_n}, 9'h2);
        chk("nt contaT", {8'd0, contaT_n}, 9'd1);
        timeout = 1'b0;

        // Reset while in comparacao.
        inicia_rodada();
        jogada_feita = 1'b1; step(); jogada_feita = 1'b0;
        step();
        chk_estado("in comparacao", 4'h5, O_CMP);
        reset = 1'b1; step(); reset = 1'b0;
        chk_estado("reset mid-round", 4'h0, O_INI);
        jogada_feita = 1'b1; step(); jogada_feita = 1'b0;
        chk_estado("jf in inicial", 4'h0, O_INI);

        // Illegal code 7 recovers to inicial.
        @(negedge clock);
        force dut.estado_q = estado_t'(4'h7);
        #1;
        chk_estado("illegal code", 4'h7, 9'd0);
        release dut.estado_q;
        step();
        chk_estado("illegal recover", 4'h0, O_INI);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
